// File: rtl/resp_misr_compactor_pkg.sv
// Shared definitions for the response MISR compactor: FSM states, default
// polynomial/seed, and the single MISR step used by RTL and bench models.
package resp_cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SKIP,
    ST_COMPACT,
    ST_DONE
  } state_t;

  localparam int MAX_W = 64;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  // Galois step over the low 'width' bits: shift left, fold the MSB back
  // through poly, then XOR in the (already zero-extended) observation.
  function automatic logic [MAX_W-1:0] misr_step(input logic [MAX_W-1:0] sig,
                                                 input logic [MAX_W-1:0] obs,
                                                 input logic [MAX_W-1:0] poly,
                                                 input int               width);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] nxt;
    mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
    nxt  = (sig << 1) & mask;
    if (sig[width-1]) nxt = nxt ^ poly;
    return (nxt ^ obs) & mask;
  endfunction

endpackage

// File: rtl/resp_misr_compactor_misr_reg.sv
// Multiple-input signature register: reloads SEED on load_seed, otherwise
// advances one Galois step per enabled cycle.
module misr_reg
  import resp_cmp_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
  parameter int               OBS_W = 2
) (
  input  logic             clk,
  input  logic             load_seed,
  input  logic             en,
  input  logic [OBS_W-1:0] obs,
  output logic [SIG_W-1:0] signature
);

  if (OBS_W < 1 || OBS_W > SIG_W) begin : g_obs_w_check
    $error("misr_reg: OBS_W must be in 1..SIG_W");
  end
  if (SIG_W < 2 || SIG_W > MAX_W) begin : g_sig_w_check
    $error("misr_reg: SIG_W must be in 2..MAX_W");
  end

  // NOTE: sequential state is written with <= so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (load_seed) begin
      signature <= SEED;
    end else if (en) begin
      signature <= SIG_W'(misr_step(MAX_W'(signature), MAX_W'(obs),
                                    MAX_W'(POLY), SIG_W));
    end
  end

endmodule

// File: rtl/resp_misr_compactor.sv
// Response-capture stage: skips pipeline-fill samples, compacts a window of
// observed outputs into a MISR and compares against a golden signature.
module resp_misr_compactor
  import resp_cmp_pkg::*;
#(
  parameter int               OBS_W = 2,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED,
  parameter int               CNT_W = 16,
  parameter int               SKIP  = 1
) (
  input  logic             tau2015_clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_cycles,
  input  logic [SIG_W-1:0] golden,
  input  logic             obs_valid,
  input  logic [OBS_W-1:0] obs,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] obs_count,
  output logic             pass
);

  localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(SKIP - 1);

  state_t           state, state_nxt;
  logic             start_ok;
  logic             compact_en;
  logic [CNT_W-1:0] skip_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] n_q;
  logic [SIG_W-1:0] golden_q;

  assign compact_en = (state == ST_COMPACT) && obs_valid;
  assign cnt_inc    = obs_count + CNT_W'(1);

  always_ff @(posedge tau2015_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: defaults first so no path through the case leaves a signal
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok = 1'b1;
          if (n_cycles == '0) state_nxt = ST_DONE;
          else if (SKIP > 0)  state_nxt = ST_SKIP;
          else                state_nxt = ST_COMPACT;
        end
      end
      ST_SKIP: begin
        if (obs_valid && skip_cnt == SKIP_LAST) state_nxt = ST_COMPACT;
      end
      ST_COMPACT: begin
        if (compact_en && cnt_inc == n_q) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counters stop advancing once DONE is reached, so obs_count never passes n_q.
  always_ff @(posedge tau2015_clk) begin
    if (rst) begin
      skip_cnt  <= '0;
      obs_count <= '0;
      n_q       <= '0;
      golden_q  <= '0;
    end else if (start_ok) begin
      skip_cnt  <= '0;
      obs_count <= '0;
      n_q       <= n_cycles;
      golden_q  <= golden;
    end else begin
      if (state == ST_SKIP && obs_valid) skip_cnt <= skip_cnt + CNT_W'(1);
      if (compact_en) obs_count <= cnt_inc;
    end
  end

  misr_reg #(
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED),
    .OBS_W(OBS_W)
  ) u_misr (
    .clk      (tau2015_clk),
    .load_seed(rst || start_ok),
    .en       (compact_en),
    .obs      (obs),
    .signature(signature)
  );

  assign busy = (state == ST_SKIP) || (state == ST_COMPACT);
  assign done = (state == ST_DONE);
  assign pass = done && (signature == golden_q);

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Directed bench for resp_misr_compactor with hand-computed signatures and a
// small gate-level upstream model for the in-loop window.
module tb_resp_misr_compactor;
  import resp_cmp_pkg::*;

  logic        tau2015_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_cycles = '0;
  logic [15:0] golden = '0;
  logic        obs_valid = 1'b0;
  logic [1:0]  obs = '0;
  logic        busy, done, pass;
  logic [15:0] signature, obs_count;

  int total = 0;
  int bad   = 0;

  resp_misr_compactor dut (
    .tau2015_clk(tau2015_clk),
    .rst        (rst),
    .start      (start),
    .n_cycles   (n_cycles),
    .golden     (golden),
    .obs_valid  (obs_valid),
    .obs        (obs),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .obs_count  (obs_count),
    .pass       (pass)
  );

  always #5 tau2015_clk = ~tau2015_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge tau2015_clk);
    #1;
  endtask

  task automatic sample(input logic v, input logic [1:0] o);
    obs_valid = v;
    obs       = o;
    step();
    obs_valid = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [15:0] g,
                          input logic v, input logic [1:0] o);
    start     = 1'b1;
    n_cycles  = n;
    golden    = g;
    obs_valid = v;
    obs       = o;
    step();
    start     = 1'b0;
    obs_valid = 1'b0;
  endtask

  // Upstream netlist: two gates feeding output DFFs, fed by a counter pattern.
  logic [1:0]  seq[65];
  logic [15:0] net_gold;

  task automatic build_netlist_window();
    logic [7:0]  i8;
    logic        a, b, c, out1, out2;
    logic [15:0] s;
    out1 = 1'b0;
    out2 = 1'b0;
    for (int k = 0; k < 65; k++) begin
      seq[k] = {out1, out2};
      i8   = 8'(k * 37 + 5);
      a    = i8[0];
      b    = i8[1];
      c    = i8[2] ^ i8[4];
      out1 = (a & b) | c;
      out2 = a ^ c;
    end
    s = 16'hFFFF;
    for (int k = 1; k < 65; k++)
      s = 16'(misr_step(64'(s), 64'(seq[k]), 64'(16'h1021), 16));
    net_gold = s;
  endtask

  task automatic run_netlist(input int flip_at);
    do_start(16'd64, net_gold, 1'b0, 2'b00);
    for (int k = 0; k < 65; k++)
      sample(1'b1, (k == flip_at) ? (seq[k] ^ 2'b01) : seq[k]);
  endtask

  initial begin
    // Reset then idle
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("rst_sig", 32'(signature), 32'h0000_FFFF);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pass", 32'(pass), 0);
    check("rst_cnt", 32'(obs_count), 0);

    // Zero window
    do_start(16'd0, 16'hFFFF, 1'b0, 2'b00);
    check("zw_done", 32'(done), 1);
    check("zw_busy", 32'(busy), 0);
    check("zw_sig", 32'(signature), 32'h0000_FFFF);
    check("zw_pass", 32'(pass), 1);
    do_start(16'd0, 16'h0000, 1'b0, 2'b00);
    check("zw_done2", 32'(done), 1);
    check("zw_pass2", 32'(pass), 0);

    // Basic compaction; the sample offered with start must not be consumed
    do_start(16'd2, 16'hCF9F, 1'b1, 2'b01);
    check("bc_busy0", 32'(busy), 1);
    check("bc_done0", 32'(done), 0);
    check("bc_sig0", 32'(signature), 32'h0000_FFFF);
    sample(1'b1, 2'b11);
    check("bc_skip_sig", 32'(signature), 32'h0000_FFFF);
    check("bc_skip_cnt", 32'(obs_count), 0);
    sample(1'b1, 2'b00);
    check("bc_sig1", 32'(signature), 32'h0000_EFDF);
    check("bc_cnt1", 32'(obs_count), 1);
    check("bc_done1", 32'(done), 0);
    sample(1'b1, 2'b00);
    check("bc_sig2", 32'(signature), 32'h0000_CF9F);
    check("bc_cnt2", 32'(obs_count), 2);
    check("bc_done2", 32'(done), 1);
    check("bc_busy2", 32'(busy), 0);
    check("bc_pass", 32'(pass), 1);
    sample(1'b1, 2'b11);
    sample(1'b1, 2'b10);
    check("bc_frozen_sig", 32'(signature), 32'h0000_CF9F);
    check("bc_frozen_cnt", 32'(obs_count), 2);
    check("bc_frozen_done", 32'(done), 1);

    // Data injection with stall
    do_start(16'd1, 16'hEFDE, 1'b0, 2'b00);
    sample(1'b1, 2'b10);
    for (int k = 0; k < 3; k++) begin
      sample(1'b0, 2'b11);
      check("st_sig", 32'(signature), 32'h0000_FFFF);
      check("st_busy", 32'(busy), 1);
      check("st_cnt", 32'(obs_count), 0);
    end
    sample(1'b1, 2'b01);
    check("st_sig_fin", 32'(signature), 32'h0000_EFDE);
    check("st_done", 32'(done), 1);
    check("st_pass", 32'(pass), 1);

    // Mid-run disturbance
    do_start(16'd5, 16'h0000, 1'b0, 2'b00);
    sample(1'b1, 2'b00);
    sample(1'b1, 2'b00);
    sample(1'b1, 2'b00);
    check("md_cnt2", 32'(obs_count), 2);
    do_start(16'd1, 16'h1234, 1'b1, 2'b00);
    check("md_ign_cnt", 32'(obs_count), 3);
    check("md_ign_busy", 32'(busy), 1);
    check("md_ign_done", 32'(done), 0);
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    check("md_rst_sig", 32'(signature), 32'h0000_FFFF);
    check("md_rst_busy", 32'(busy), 0);
    check("md_rst_done", 32'(done), 0);
    check("md_rst_cnt", 32'(obs_count), 0);
    do_start(16'd2, 16'hCF9F, 1'b0, 2'b00);
    sample(1'b1, 2'b11);
    sample(1'b1, 2'b00);
    sample(1'b1, 2'b00);
    check("md_re_sig", 32'(signature), 32'h0000_CF9F);
    check("md_re_pass", 32'(pass), 1);

    // Netlist in the loop
    build_netlist_window();
    run_netlist(-1);
    check("nl_done", 32'(done), 1);
    check("nl_cnt", 32'(obs_count), 64);
    check("nl_sig", 32'(signature), 32'(net_gold));
    check("nl_pass", 32'(pass), 1);
    run_netlist(30);
    check("nl_flip_done", 32'(done), 1);
    check("nl_flip_pass", 32'(pass), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
